// File: rtl/game_timer_pkg.sv
// Shared definitions for the game timer blocks: countdown FSM states,
// BCD digit width and helpers that split a seconds value into BCD digits.
package game_timer_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Tens digit of a seconds value in 0..99
    function automatic logic [BCD_W-1:0] to_bcd_tens(input int unsigned value);
        return BCD_W'(value / 10);
    endfunction

    // Ones digit of a seconds value in 0..99
    function automatic logic [BCD_W-1:0] to_bcd_ones(input int unsigned value);
        return BCD_W'(value % 10);
    endfunction

endpackage

// File: rtl/game_countdown_if.sv
// Control and display bundle of the round countdown. The game side (master)
// drives tick/start/hold; the countdown (slave) returns digits and status.
interface game_countdown_if;
    import game_timer_pkg::*;

    logic             tick;
    logic             start;
    logic             hold;
    logic [BCD_W-1:0] secs_tens;
    logic [BCD_W-1:0] secs_ones;
    logic             running;
    logic             expired;
    logic             game_over;
    logic             warn;

    modport master (
        output tick, start, hold,
        input  secs_tens, secs_ones, running, expired, game_over, warn
    );

    modport slave (
        input  tick, start, hold,
        output secs_tens, secs_ones, running, expired, game_over, warn
    );
endinterface

// File: rtl/game_countdown_tick_edge_detect.sv
// Rising-edge detector for slow strobes and button levels: one flop plus
// an AND gate, so a level held high for many cycles yields a single pulse.
module tick_edge_detect (
    input  logic clk_in,
    input  logic rst,
    input  logic tick,
    output logic tick_rise
);

    logic tick_q;

    // Remember the previous sample of the strobe
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
        end
    end

    assign tick_rise = tick & ~tick_q;

endmodule

// File: rtl/game_countdown.sv
// Round countdown for whack-a-mole: loads GAME_SECONDS on start, counts
// down one second per tick rising edge in BCD, and flags the end of round.
// Optional feature macro: COUNTDOWN_WARN_EN builds the low-time warn flag;
// without it warn is tied low and no compare logic exists.
module game_countdown
    import game_timer_pkg::*;
#(
    parameter int GAME_SECONDS = 60,
    parameter int WARN_SECONDS = 10
) (
    input  logic              clk_in,
    input  logic              rst,
    game_countdown_if.slave   bus
);

    localparam logic [BCD_W-1:0] RELOAD_TENS = to_bcd_tens(GAME_SECONDS);
    localparam logic [BCD_W-1:0] RELOAD_ONES = to_bcd_ones(GAME_SECONDS);

    // Refuse to elaborate with a round length or threshold out of range
    if (GAME_SECONDS < 1 || GAME_SECONDS > 99 ||
        WARN_SECONDS < 0 || WARN_SECONDS > GAME_SECONDS) begin : g_bad_param
        $error("game_countdown: GAME_SECONDS/WARN_SECONDS out of range");
    end

    state_t           state_q, state_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;
    logic             game_over_q, game_over_d;
    logic             tick_rise;

    tick_edge_detect u_tick_edge (
        .clk_in    (clk_in),
        .rst       (rst),
        .tick      (bus.tick),
        .tick_rise (tick_rise)
    );

    // Next state and counter: start overrides everything, hold overrides a tick
    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        expired_d = 1'b0;
        if (bus.start) begin
            tens_d  = RELOAD_TENS;
            ones_d  = RELOAD_ONES;
            state_d = bus.hold ? ST_PAUSE : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.hold) begin
                        state_d = ST_PAUSE;
                    end else if (tick_rise) begin
                        if (ones_q != '0) begin
                            ones_d = ones_q - 1'b1;
                        end else if (tens_q != '0) begin
                            ones_d = BCD_W'(9);
                            tens_d = tens_q - 1'b1;
                        end
                        // Final second just elapsed: 01 -> 00 ends the round
                        if (tens_q == '0 && ones_q == BCD_W'(1)) begin
                            state_d   = ST_DONE;
                            expired_d = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!bus.hold) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
        running_d   = (state_d == ST_RUN);
        game_over_d = (state_d == ST_DONE);
    end

    // State, digits and status flags
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tens_q      <= RELOAD_TENS;
            ones_q      <= RELOAD_ONES;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            running_q   <= running_d;
            expired_q   <= expired_d;
            game_over_q <= game_over_d;
        end
    end

`ifdef COUNTDOWN_WARN_EN
    logic       warn_q, warn_d;
    logic [6:0] remain_d;

    // Warn compares the next count so it moves on the same edge as the digits
    always_comb begin
        remain_d = {3'b000, tens_d} * 7'd10 + {3'b000, ones_d};
        warn_d   = ((state_d == ST_RUN) || (state_d == ST_PAUSE)) &&
                   (remain_d <= 7'(WARN_SECONDS));
    end

    // Registered warn flag
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign bus.warn = warn_q;
`else
    assign bus.warn = 1'b0;
`endif

    assign bus.secs_tens = tens_q;
    assign bus.secs_ones = ones_q;
    assign bus.running   = running_q;
    assign bus.expired   = expired_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_countdown.sv
// Directed bench for game_countdown with GAME_SECONDS=60, WARN_SECONDS=10.
module tb_game_countdown;

    localparam int GS = 60;
    localparam int WS = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt;          // expected remaining seconds
    logic active;       // expected RUN or PAUSE

    game_countdown_if bus ();

    game_countdown #(.GAME_SECONDS(GS), .WARN_SECONDS(WS)) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_warn(input int c, input logic act);
`ifdef COUNTDOWN_WARN_EN
        return act && (c <= WS);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_digits(input string tag);
        chk({tag, "_tens"}, 32'(bus.secs_tens), 32'(cnt / 10));
        chk({tag, "_ones"}, 32'(bus.secs_ones), 32'(cnt % 10));
        chk({tag, "_warn"}, 32'(bus.warn), 32'(exp_warn(cnt, active)));
    endtask

    // Single-cycle tick; outputs are inspected right after the sampling edge
    task automatic tick_pulse();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cnt = GS;
        active = 1'b1;
    endtask

    // Run ticks until the count reaches the target, checking each step
    task automatic tick_down_to(input int target);
        while (cnt > target) begin
            tick_pulse();
            cnt--;
            chk_digits("walk");
            repeat (2) step();
        end
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.start = 1'b0;
        bus.hold = 1'b0;
        cnt = GS;
        active = 1'b0;

        // Reset state
        repeat (3) step();
        chk_digits("rst");
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_game_over", 32'(bus.game_over), 0);
        chk("rst_expired", 32'(bus.expired), 0);
        rst = 1'b0;
        step();

        // Start, then a full round of 60 ticks spaced 10 cycles apart
        start_pulse();
        chk_digits("start");
        chk("start_running", 32'(bus.running), 1);
        for (int i = 1; i <= GS; i++) begin
            tick_pulse();
            cnt--;
            if (cnt == 0) active = 1'b0;
            chk_digits("round");
            chk("round_expired", 32'(bus.expired), (cnt == 0) ? 1 : 0);
            chk("round_running", 32'(bus.running), (cnt == 0) ? 0 : 1);
            chk("round_game_over", 32'(bus.game_over), (cnt == 0) ? 1 : 0);
            $display("tick %0d -> %0d%0d", i, bus.secs_tens, bus.secs_ones);
            step();
            if (cnt == 0) begin
                chk("expired_once", 32'(bus.expired), 0);
                chk("done_game_over", 32'(bus.game_over), 1);
            end
            repeat (8) step();
        end

        // 61st tick in DONE leaves 00
        tick_pulse();
        chk_digits("extra_tick");
        chk("extra_game_over", 32'(bus.game_over), 1);
        chk("extra_running", 32'(bus.running), 0);
        step();

        // start from DONE reloads and runs
        start_pulse();
        chk_digits("restart");
        chk("restart_running", 32'(bus.running), 1);
        chk("restart_game_over", 32'(bus.game_over), 0);
        $display("restart from DONE -> %0d%0d", bus.secs_tens, bus.secs_ones);

        // Tick held high for 20 cycles counts once
        bus.tick = 1'b1;
        repeat (20) step();
        bus.tick = 1'b0;
        step();
        cnt = GS - 1;
        chk_digits("held_tick");
        $display("held tick -> %0d%0d", bus.secs_tens, bus.secs_ones);

        // Asynchronous reset mid-round at 42
        tick_down_to(42);
        rst = 1'b1;
        #1;
        cnt = GS;
        active = 1'b0;
        chk_digits("async_rst");
        chk("async_rst_running", 32'(bus.running), 0);
        chk("async_rst_game_over", 32'(bus.game_over), 0);
        $display("async reset at 42 -> %0d%0d", bus.secs_tens, bus.secs_ones);
        step();
        rst = 1'b0;
        step();

        // Hold at 30: tick coincident with hold is dropped, ticks ignored in PAUSE
        start_pulse();
        tick_down_to(30);
        bus.hold = 1'b1;
        tick_pulse();
        chk_digits("hold_edge");
        chk("hold_running", 32'(bus.running), 0);
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            tick_pulse();
            chk_digits("paused");
            repeat (2) step();
        end
        bus.hold = 1'b0;
        step();
        chk("resume_running", 32'(bus.running), 1);
        tick_down_to(28);
        chk("after_pause_ones", 32'(bus.secs_ones), 8);
        $display("pause sequence -> %0d%0d", bus.secs_tens, bus.secs_ones);

        // start coincident with tick at 15: reload, no decrement
        tick_down_to(15);
        bus.start = 1'b1;
        bus.tick = 1'b1;
        step();
        bus.start = 1'b0;
        bus.tick = 1'b0;
        cnt = GS;
        chk_digits("start_tick");
        chk("start_tick_running", 32'(bus.running), 1);
        chk("start_tick_expired", 32'(bus.expired), 0);
        step();
        chk_digits("start_tick_after");
        $display("start+tick at 15 -> %0d%0d", bus.secs_tens, bus.secs_ones);

        // start with hold: reload into PAUSE, then resume
        tick_down_to(55);
        bus.start = 1'b1;
        bus.hold = 1'b1;
        step();
        bus.start = 1'b0;
        cnt = GS;
        chk_digits("start_hold");
        chk("start_hold_running", 32'(bus.running), 0);
        chk("start_hold_game_over", 32'(bus.game_over), 0);
        bus.hold = 1'b0;
        step();
        step();
        chk("start_hold_resume", 32'(bus.running), 1);
        $display("start+hold -> %0d%0d running=%0d", bus.secs_tens, bus.secs_ones, bus.running);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
